// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types and constants for the main_mem port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef logic [31:0] data_val;
    typedef logic [2:0]  l_s_sel;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int ARB_REQ_D = 0;
    localparam int ARB_REQ_L = 1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_sat_counter.sv
// ============================================================================
// Module   : arb_sat_counter
// Brief    : Saturating up-counter with clear; clear+inc together loads one.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_sat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int WIDTH = cnt_width(MAX);
    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    assign o_at_max = (r_cnt == c_max);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= WIDTH'(i_inc);
        end else if (i_inc && !o_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares main_mem between the pipeline MEM stage (D) and the
//            loader/debug port (L) with starvation guard and bounded locks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 64
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_d_req,
    input  data_val i_d_addr,
    input  logic    i_d_wr_en,
    input  data_val i_d_wr_val,
    input  l_s_sel  i_d_l_s_sel,
    output logic    o_d_gnt,
    output data_val o_d_rd_val,
    output logic    o_stall,
    input  logic    i_l_req,
    input  data_val i_l_addr,
    input  logic    i_l_wr_en,
    input  data_val i_l_wr_val,
    input  l_s_sel  i_l_l_s_sel,
    input  logic    i_l_lock,
    output logic    o_l_gnt,
    output data_val o_l_rd_val,
    output data_val o_m_addr,
    output logic    o_m_wr_en,
    output data_val o_m_wr_val,
    output l_s_sel  o_m_l_s_sel,
    input  data_val i_m_rd_val
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_relock_block;
    logic [1:0] w_gnt;
    logic       w_starve_at_max;
    logic       w_lock_at_max;
    logic       w_starve_clr;
    logic       w_starve_inc;
    logic       w_lock_clr;
    logic       w_lock_inc;

    always_comb begin
        w_gnt       = '0;
        w_state_nxt = r_state;
        if (!i_rst) begin
            case (r_state)
                ARB: begin
                    if (i_l_req && (!i_d_req || w_starve_at_max)) begin
                        w_gnt[ARB_REQ_L] = 1'b1;
                    end else if (i_d_req) begin
                        w_gnt[ARB_REQ_D] = 1'b1;
                    end
                    if (w_gnt[ARB_REQ_L] && i_l_lock && !r_relock_block) begin
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    // The deassertion cycle itself still belongs to L.
                    w_gnt[ARB_REQ_L] = i_l_req;
                    if (!i_l_lock || w_lock_at_max) begin
                        w_state_nxt = ARB;
                    end
                end
                default: w_state_nxt = ARB;
            endcase
        end
    end

    assign o_d_gnt = w_gnt[ARB_REQ_D];
    assign o_l_gnt = w_gnt[ARB_REQ_L];
    assign o_stall = i_d_req & ~w_gnt[ARB_REQ_D];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ARB;
            r_relock_block <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!i_l_lock) begin
                r_relock_block <= 1'b0;
            end else if (r_state == LOCKED && w_lock_at_max) begin
                r_relock_block <= 1'b1;
            end
        end
    end

    assign w_starve_inc = i_l_req & ~w_gnt[ARB_REQ_L];
    assign w_starve_clr = w_gnt[ARB_REQ_L] | ~i_l_req;
    // Lock count is loaded to one on entry, then counts every LOCKED cycle.
    assign w_lock_clr   = (r_state != LOCKED);
    assign w_lock_inc   = (r_state == LOCKED) || (w_state_nxt == LOCKED);

    arb_sat_counter #(
        .MAX (STARVE_LIMIT)
    ) u_starve_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_starve_clr),
        .i_inc    (w_starve_inc),
        .o_at_max (w_starve_at_max)
    );

    arb_sat_counter #(
        .MAX (LOCK_MAX)
    ) u_lock_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_lock_clr),
        .i_inc    (w_lock_inc),
        .o_at_max (w_lock_at_max)
    );

    always_comb begin
        o_m_addr    = i_d_addr;
        o_m_l_s_sel = i_d_l_s_sel;
        o_m_wr_en   = 1'b0;
        o_m_wr_val  = '0;
        if (w_gnt[ARB_REQ_L]) begin
            o_m_addr    = i_l_addr;
            o_m_l_s_sel = i_l_l_s_sel;
            o_m_wr_en   = i_l_wr_en;
            o_m_wr_val  = i_l_wr_val;
        end else if (w_gnt[ARB_REQ_D]) begin
            o_m_wr_en   = i_d_wr_en;
            o_m_wr_val  = i_d_wr_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_d_rd_val <= '0;
            o_l_rd_val <= '0;
        end else begin
            if (w_gnt[ARB_REQ_D] && !i_d_wr_en) begin
                o_d_rd_val <= i_m_rd_val;
            end
            if (w_gnt[ARB_REQ_L] && !i_l_wr_en) begin
                o_l_rd_val <= i_m_rd_val;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter with a small
//            behavioural main_mem.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        d_req, d_wr_en, l_req, l_wr_en, l_lock;
    logic [31:0] d_addr, d_wr_val, l_addr, l_wr_val;
    logic [2:0]  d_lss, l_lss;

    logic        d_gnt, l_gnt, stall, m_wr_en;
    logic [31:0] d_rd_val, l_rd_val, m_addr, m_wr_val, m_rd;
    logic [2:0]  m_lss;

    logic        d8_gnt, l8_gnt, stall8, m8_wr_en;
    logic [31:0] d8_rd_val, l8_rd_val, m8_addr, m8_wr_val, m8_rd;
    logic [2:0]  m8_lss;

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wr_en(d_wr_en),
        .i_d_wr_val(d_wr_val), .i_d_l_s_sel(d_lss),
        .o_d_gnt(d_gnt), .o_d_rd_val(d_rd_val), .o_stall(stall),
        .i_l_req(l_req), .i_l_addr(l_addr), .i_l_wr_en(l_wr_en),
        .i_l_wr_val(l_wr_val), .i_l_l_s_sel(l_lss), .i_l_lock(l_lock),
        .o_l_gnt(l_gnt), .o_l_rd_val(l_rd_val),
        .o_m_addr(m_addr), .o_m_wr_en(m_wr_en), .o_m_wr_val(m_wr_val),
        .o_m_l_s_sel(m_lss), .i_m_rd_val(m_rd)
    );

    mem_port_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(8)) dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wr_en(d_wr_en),
        .i_d_wr_val(d_wr_val), .i_d_l_s_sel(d_lss),
        .o_d_gnt(d8_gnt), .o_d_rd_val(d8_rd_val), .o_stall(stall8),
        .i_l_req(l_req), .i_l_addr(l_addr), .i_l_wr_en(l_wr_en),
        .i_l_wr_val(l_wr_val), .i_l_l_s_sel(l_lss), .i_l_lock(l_lock),
        .o_l_gnt(l8_gnt), .o_l_rd_val(l8_rd_val),
        .o_m_addr(m8_addr), .o_m_wr_en(m8_wr_en), .o_m_wr_val(m8_wr_val),
        .o_m_l_s_sel(m8_lss), .i_m_rd_val(m8_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the main instance writes the model memory; the LOCK_MAX=8 copy reads it.
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (m_wr_en) mem[m_addr[9:2]] <= m_wr_val;
    end
    assign m_rd  = mem[m_addr[9:2]];
    assign m8_rd = mem[m8_addr[9:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        step();
        pl_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] pat4;
        rst = 1'b1;
        d_req = 0; d_wr_en = 0; d_addr = 0; d_wr_val = 0; d_lss = 3'd2;
        l_req = 0; l_wr_en = 0; l_addr = 0; l_wr_val = 0; l_lss = 3'd2; l_lock = 0;
        pl_en = 0; pl_idx = 0; pl_val = 0;
        step();
        preload(8'h40, 32'hDEADBEEF);
        preload(8'h41, 32'h12345678);
        preload(8'h42, 32'hCAFEF00D);
        preload(8'h20, 32'h11111111);

        // Grants and write enable forced low while reset is held.
        d_req = 1; l_req = 1; l_wr_en = 1;
        settle();
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rst_m_wr_en", {31'd0, m_wr_en}, 32'd0);
        step();
        rst = 0; d_req = 0; l_req = 0; l_wr_en = 0;
        settle();
        chk("rst_d_rd_val", d_rd_val, 32'd0);
        chk("rst_l_rd_val", l_rd_val, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // D-only read.
        step();
        d_req = 1; d_addr = 32'h100;
        settle();
        chk("t1_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("t1_stall", {31'd0, stall}, 32'd0);
        chk("t1_m_addr", m_addr, 32'h100);
        step();
        d_req = 0;
        settle();
        chk("t1_d_rd_val", d_rd_val, 32'hDEADBEEF);

        // L-only read.
        l_req = 1; l_addr = 32'h108;
        settle();
        chk("tl_l_gnt", {31'd0, l_gnt}, 32'd1);
        step();
        l_req = 0;
        settle();
        chk("tl_l_rd_val", l_rd_val, 32'hCAFEF00D);
        chk("tl_d_rd_hold", d_rd_val, 32'hDEADBEEF);

        // Both requesting continuously: D,D,D,D,L repeating.
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                d_req = 1; d_addr = 32'h100;
                l_req = 1; l_addr = 32'h104;
            end
            settle();
            chk($sformatf("t2_d_gnt_%0d", i), {31'd0, d_gnt}, {31'd0, (i % 5) != 4});
            chk($sformatf("t2_l_gnt_%0d", i), {31'd0, l_gnt}, {31'd0, (i % 5) == 4});
            chk($sformatf("t2_stall_%0d", i), {31'd0, stall}, {31'd0, (i % 5) == 4});
        end

        // Idle: nothing granted, read data held, memory port defaults.
        step();
        d_req = 0; l_req = 0; d_addr = 32'h1F0;
        settle();
        chk("t6_l_rd_val", l_rd_val, 32'h12345678);
        chk("t6_d_rd_val", d_rd_val, 32'hDEADBEEF);
        chk("t6_m_wr_en", {31'd0, m_wr_en}, 32'd0);
        chk("t6_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("t6_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("t6_m_addr", m_addr, 32'h1F0);
        chk("t6_m_wr_val", m_wr_val, 32'd0);
        step();
        settle();
        chk("t6_d_rd_hold", d_rd_val, 32'hDEADBEEF);
        chk("t6_l_rd_hold", l_rd_val, 32'h12345678);

        // Locked burst of 10 writes; L first wins through the starvation guard.
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) begin
                d_req = 1; d_addr = 32'h100; d_wr_en = 0;
                l_req = 1; l_lock = 1; l_wr_en = 1; l_addr = 32'h0; l_wr_val = 32'hA0000000;
            end
            settle();
            chk($sformatf("t3_pre_d_gnt_%0d", c), {31'd0, d_gnt}, 32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            l_addr = 32'(4 * k);
            l_wr_val = 32'hA0000000 + 32'(k);
            l_lock = (k != 9);
            settle();
            chk($sformatf("t3_l_gnt_%0d", k), {31'd0, l_gnt}, 32'd1);
            chk($sformatf("t3_stall_%0d", k), {31'd0, stall}, 32'd1);
            chk($sformatf("t3_m_addr_%0d", k), m_addr, 32'(4 * k));
            chk($sformatf("t3_m_wr_en_%0d", k), {31'd0, m_wr_en}, 32'd1);
        end
        step();
        l_req = 0; l_wr_en = 0;
        settle();
        chk("t3_d_gnt_after", {31'd0, d_gnt}, 32'd1);
        chk("t3_stall_after", {31'd0, stall}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_mem_%0d", k), mem[k], 32'hA0000000 + 32'(k));
        end

        // Reset in the middle of a lock with an L write pending.
        step();
        d_req = 0;
        l_req = 1; l_lock = 1; l_wr_en = 1; l_addr = 32'h0; l_wr_val = 32'hBBBB0000;
        settle();
        chk("t5_l_gnt_entry", {31'd0, l_gnt}, 32'd1);
        step();
        l_addr = 32'h80; l_wr_val = 32'h55AA55AA; rst = 1; d_req = 1;
        settle();
        chk("t5_rst_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("t5_rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("t5_rst_m_wr_en", {31'd0, m_wr_en}, 32'd0);
        step();
        rst = 0; l_req = 0; l_lock = 0; l_wr_en = 0; d_req = 0;
        settle();
        chk("t5_mem_untouched", mem[32], 32'h11111111);
        chk("t5_d_rd_val", d_rd_val, 32'd0);
        chk("t5_l_rd_val", l_rd_val, 32'd0);
        step();
        d_req = 1; l_req = 1; l_addr = 32'h104;
        settle();
        chk("t5_state_arb", {31'd0, d_gnt}, 32'd1);

        // Lock timeout on the LOCK_MAX=8 instance.
        step();
        rst = 1; d_req = 0; l_req = 0;
        step();
        rst = 0; l_req = 1; l_lock = 1; l_wr_en = 0; l_addr = 32'h104;
        settle();
        chk("t4_entry_l_gnt", {31'd0, l8_gnt}, 32'd1);
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) d_req = 1;
            settle();
            chk($sformatf("t4_lock_l_gnt_%0d", c), {31'd0, l8_gnt}, 32'd1);
            chk($sformatf("t4_lock_stall_%0d", c), {31'd0, stall8}, 32'd1);
        end
        // After forced exit: L wins only via starvation, no relock until lock drops at X6.
        pat4 = 11'b11000010000;
        for (int x = 0; x < 11; x++) begin
            step();
            l_lock = (x != 6);
            settle();
            chk($sformatf("t4_post_l_gnt_%0d", x), {31'd0, l8_gnt}, {31'd0, pat4[x]});
            chk($sformatf("t4_post_d_gnt_%0d", x), {31'd0, d8_gnt}, {31'd0, ~pat4[x]});
        end

        step();
        d_req = 0; l_req = 0; l_lock = 0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
